// File: rtl/usb_txn_pkg.sv
// usb_txn_pkg: shared types for the USB device transaction sequencer.
// Holds the decoded rx PID encoding, the transmit request encoding, the sequencer
// state encoding and the post-transmit action code. The AHB subordinate and the
// transmitter import this package as well.
// Related build macro: USB_TXN_STALL_EN (see usb_txn_ctrl).
package usb_txn_pkg;

  typedef enum logic [2:0] {
    RX_NONE  = 3'd0,
    RX_OUT   = 3'd1,
    RX_IN    = 3'd2,
    RX_DATA0 = 3'd3,
    RX_DATA1 = 3'd4,
    RX_ACK   = 3'd5,
    RX_NAK   = 3'd6,
    RX_OTHER = 3'd7
  } rx_pid_t;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_pid_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OUT_WAIT  = 3'd1,
    ST_IN_DECIDE = 3'd2,
    ST_TX_REQ    = 3'd3,
    ST_TX_START  = 3'd4,
    ST_TX_BUSY   = 3'd5,
    ST_ACK_WAIT  = 3'd6
  } state_t;

  // What happens once the transmitter goes idle again.
  typedef enum logic [1:0] {
    POST_NONE     = 2'd0,
    POST_RX_DONE  = 2'd1,
    POST_ACK_WAIT = 2'd2
  } post_t;

endpackage

// File: rtl/usb_txn_timer.sv
// usb_txn_timer: saturating timeout counter for the transaction sequencer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (has priority over en)
//   en        - count one cycle while waiting
//   expired   - counter has reached TIMEOUT_CYCLES (holds there)
module usb_txn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: USB device transaction sequencer.
// Watches decoded rx packets, chooses the handshake / data response, requests
// transmission, gates and flushes the shared data buffer and tracks the DATA0/1
// toggles for each direction. All outputs are registered.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_packet           - decoded rx PID (rx_pid_t), valid with rx_data_ready
//   rx_data_ready       - packet-complete pulse
//   rx_error            - receiver error pulse
//   tx_transfer_active  - transmitter busy
//   tx_error            - transmitter error pulse
//   buffer_occupancy    - bytes currently in the data buffer
//   tx_arm              - software staged an IN payload
//   toggle_clr          - force both toggles back to DATA0
//   stall               - (USB_TXN_STALL_EN only) answer tokens with STALL
//   tx_packet           - transmit request (tx_pid_t), one-cycle pulse
//   d_mode              - device owns the bus
//   flush               - one-cycle buffer flush
//   rx_accept           - receiver may store into the buffer
//   rx_done, tx_done, txn_error - one-cycle status pulses
//   tx_armed            - IN payload pending
// Build macro: USB_TXN_STALL_EN adds the stall input and STALL responses.
module usb_txn_ctrl
  import usb_txn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BUF_DEPTH      = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         rx_packet,
  input  logic                               rx_data_ready,
  input  logic                               rx_error,
  input  logic                               tx_transfer_active,
  input  logic                               tx_error,
  input  logic [$clog2(BUF_DEPTH + 1)-1:0]   buffer_occupancy,
  input  logic                               tx_arm,
  input  logic                               toggle_clr,
`ifdef USB_TXN_STALL_EN
  input  logic                               stall,
`endif
  output logic [2:0]                         tx_packet,
  output logic                               d_mode,
  output logic                               flush,
  output logic                               rx_accept,
  output logic                               rx_done,
  output logic                               tx_done,
  output logic                               txn_error,
  output logic                               tx_armed
);

  state_t  state_q, state_d;
  tx_pid_t pid_q, pid_d;
  tx_pid_t tx_packet_q, tx_packet_d;
  post_t   post_q, post_d;
  logic    busy_q, busy_d;
  logic    in_path_q, in_path_d;
  logic    rx_tgl_q, rx_tgl_d;
  logic    tx_tgl_q, tx_tgl_d;
  logic    tx_armed_q, tx_armed_d;
  logic    rx_accept_q, rx_accept_d;
  logic    d_mode_q, d_mode_d;
  logic    flush_q, flush_d;
  logic    rx_done_q, rx_done_d;
  logic    tx_done_q, tx_done_d;
  logic    txn_error_q, txn_error_d;
  logic    arm_clr;
  logic    stall_on;
  logic    is_token, is_data;
  logic    tmr_clear, tmr_en, tmr_expired;

`ifdef USB_TXN_STALL_EN
  assign stall_on = stall;
`else
  assign stall_on = 1'b0;
`endif

  assign is_token = (rx_packet == RX_OUT) || (rx_packet == RX_IN);
  assign is_data  = (rx_packet == RX_DATA0) || (rx_packet == RX_DATA1);

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    post_d      = post_q;
    busy_d      = busy_q;
    in_path_d   = in_path_q;
    rx_tgl_d    = rx_tgl_q;
    tx_tgl_d    = tx_tgl_q;
    rx_accept_d = rx_accept_q;
    tx_packet_d = TX_NONE;
    flush_d     = 1'b0;
    rx_done_d   = 1'b0;
    tx_done_d   = 1'b0;
    txn_error_d = 1'b0;
    arm_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_ready && is_token) begin
          if (stall_on) begin
            // STALL takes the OUT_WAIT-like route so its latency matches other replies.
            pid_d     = TX_STALL;
            post_d    = POST_NONE;
            in_path_d = 1'b0;
            state_d   = ST_TX_REQ;
          end else if (rx_packet == RX_OUT) begin
            busy_d      = tx_armed_q || (buffer_occupancy != '0);
            rx_accept_d = !(tx_armed_q || (buffer_occupancy != '0));
            state_d     = ST_OUT_WAIT;
          end else begin
            state_d = ST_IN_DECIDE;
          end
        end
      end

      ST_OUT_WAIT: begin
        if (rx_error || tmr_expired || (rx_data_ready && !is_data)) begin
          flush_d     = rx_accept_q;
          txn_error_d = 1'b1;
          rx_accept_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (rx_data_ready) begin
          rx_accept_d = 1'b0;
          in_path_d   = 1'b0;
          state_d     = ST_TX_REQ;
          if (busy_q) begin
            pid_d  = TX_NAK;
            post_d = POST_NONE;
          end else if ((rx_packet == RX_DATA1) == rx_tgl_q) begin
            pid_d  = TX_ACK;
            post_d = POST_RX_DONE;
          end else begin
            // Duplicate of data already taken: ACK it again and drop the copy.
            pid_d   = TX_ACK;
            post_d  = POST_NONE;
            flush_d = 1'b1;
          end
        end
      end

      ST_IN_DECIDE: begin
        in_path_d = 1'b1;
        state_d   = ST_TX_REQ;
        if (tx_armed_q) begin
          pid_d  = tx_tgl_q ? TX_DATA1 : TX_DATA0;
          post_d = POST_ACK_WAIT;
        end else begin
          pid_d  = TX_NAK;
          post_d = POST_NONE;
        end
        // IN replies are issued one cycle earlier so both token types see 2-cycle latency.
        tx_packet_d = pid_d;
      end

      ST_TX_REQ: begin
        if (!in_path_q) begin
          tx_packet_d = pid_q;
        end
        state_d = ST_TX_START;
      end

      ST_TX_START: begin
        if (tx_error || tmr_expired) begin
          txn_error_d = 1'b1;
          flush_d     = 1'b1;
          arm_clr     = 1'b1;
          state_d     = ST_IDLE;
        end else if (tx_transfer_active) begin
          state_d = ST_TX_BUSY;
        end
      end

      ST_TX_BUSY: begin
        if (tx_error) begin
          txn_error_d = 1'b1;
          flush_d     = 1'b1;
          arm_clr     = 1'b1;
          state_d     = ST_IDLE;
        end else if (!tx_transfer_active) begin
          state_d = ST_IDLE;
          case (post_q)
            POST_RX_DONE: begin
              // Toggle flips only once the ACK has actually gone out.
              rx_done_d = 1'b1;
              rx_tgl_d  = !rx_tgl_q;
            end
            POST_ACK_WAIT: state_d = ST_ACK_WAIT;
            default: ;
          endcase
        end
      end

      ST_ACK_WAIT: begin
        if (rx_error || tmr_expired || (rx_data_ready && (rx_packet != RX_ACK))) begin
          txn_error_d = 1'b1;
          flush_d     = 1'b1;
          arm_clr     = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_data_ready) begin
          tx_tgl_d  = !tx_tgl_q;
          tx_done_d = 1'b1;
          arm_clr   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (toggle_clr) begin
      rx_tgl_d = 1'b0;
      tx_tgl_d = 1'b0;
    end

    // A fresh arm beats a same-cycle clear.
    tx_armed_d = tx_arm ? 1'b1 : (arm_clr ? 1'b0 : tx_armed_q);

    d_mode_d = (state_d == ST_TX_REQ) || (state_d == ST_TX_START) ||
               (state_d == ST_TX_BUSY);
  end

  assign tmr_en    = (state_q == ST_OUT_WAIT) || (state_q == ST_TX_START) ||
                     (state_q == ST_ACK_WAIT);
  assign tmr_clear = (state_d != state_q) &&
                     ((state_d == ST_OUT_WAIT) || (state_d == ST_TX_START) ||
                      (state_d == ST_ACK_WAIT));

  usb_txn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pid_q       <= TX_NONE;
      tx_packet_q <= TX_NONE;
      post_q      <= POST_NONE;
      busy_q      <= 1'b0;
      in_path_q   <= 1'b0;
      rx_tgl_q    <= 1'b0;
      tx_tgl_q    <= 1'b0;
      tx_armed_q  <= 1'b0;
      rx_accept_q <= 1'b0;
      d_mode_q    <= 1'b0;
      flush_q     <= 1'b0;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      txn_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      tx_packet_q <= tx_packet_d;
      post_q      <= post_d;
      busy_q      <= busy_d;
      in_path_q   <= in_path_d;
      rx_tgl_q    <= rx_tgl_d;
      tx_tgl_q    <= tx_tgl_d;
      tx_armed_q  <= tx_armed_d;
      rx_accept_q <= rx_accept_d;
      d_mode_q    <= d_mode_d;
      flush_q     <= flush_d;
      rx_done_q   <= rx_done_d;
      tx_done_q   <= tx_done_d;
      txn_error_q <= txn_error_d;
    end
  end

  assign tx_packet = tx_packet_q;
  assign d_mode    = d_mode_q;
  assign flush     = flush_q;
  assign rx_accept = rx_accept_q;
  assign rx_done   = rx_done_q;
  assign tx_done   = tx_done_q;
  assign txn_error = txn_error_q;
  assign tx_armed  = tx_armed_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Bench for usb_txn_ctrl. A transaction-level model (toggle bits and the armed
// flag) predicts each handshake, status pulse and flag; directed steps cover
// reset, timeout, transmit error and arm/clear collisions, then random traffic.
// Build macro USB_TXN_STALL_EN enables the stall port and its check.
module tb_usb_txn_ctrl;
  import usb_txn_pkg::*;

  localparam int unsigned TO = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_packet = 3'd0;
  logic       rx_data_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic       tx_transfer_active = 1'b0;
  logic       tx_error = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_arm = 1'b0;
  logic       toggle_clr = 1'b0;
`ifdef USB_TXN_STALL_EN
  logic       stall = 1'b0;
`endif
  logic [2:0] tx_packet;
  logic       d_mode, flush, rx_accept, rx_done, tx_done, txn_error, tx_armed;

  usb_txn_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .BUF_DEPTH(64)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rx_packet          (rx_packet),
    .rx_data_ready      (rx_data_ready),
    .rx_error           (rx_error),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .buffer_occupancy   (buffer_occupancy),
    .tx_arm             (tx_arm),
    .toggle_clr         (toggle_clr),
`ifdef USB_TXN_STALL_EN
    .stall              (stall),
`endif
    .tx_packet          (tx_packet),
    .d_mode             (d_mode),
    .flush              (flush),
    .rx_accept          (rx_accept),
    .rx_done            (rx_done),
    .tx_done            (tx_done),
    .txn_error          (txn_error),
    .tx_armed           (tx_armed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the host/device protocol says should be true.
  bit m_rx_tgl = 1'b0;
  bit m_tx_tgl = 1'b0;
  bit m_armed  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic token(input rx_pid_t p);
    rx_packet     = p;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    rx_packet     = RX_NONE;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_packet"}, tx_packet, TX_NONE);
    check({tag, "_d_mode"}, d_mode, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_rx_accept"}, rx_accept, 0);
    check({tag, "_rx_done"}, rx_done, 0);
    check({tag, "_tx_done"}, tx_done, 0);
    check({tag, "_txn_error"}, txn_error, 0);
    check({tag, "_tx_armed"}, tx_armed, 0);
  endtask

  // Enter in TX_START; the transmitter stays busy for len cycles.
  task automatic xmit(input int len);
    tx_transfer_active = 1'b1;
    repeat (len) begin
      tick();
      check("d_mode_busy", d_mode, 1);
    end
    tx_transfer_active = 1'b0;
    tick();
    check("d_mode_end", d_mode, 0);
  endtask

  task automatic arm();
    tx_arm = 1'b1;
    tick();
    tx_arm = 1'b0;
    m_armed = 1'b1;
    check("arm", tx_armed, 1);
  endtask

  task automatic out_txn(input rx_pid_t dp, input logic [6:0] occ, input int len);
    bit acc;
    bit fresh;
    acc   = !m_armed && (occ == 7'd0);
    fresh = ((dp == RX_DATA1) == m_rx_tgl);
    buffer_occupancy = occ;
    token(RX_OUT);
    check("out_rx_accept", rx_accept, acc);
    token(dp);
    check("out_flush", flush, acc && !fresh);
    check("out_pkt_early", tx_packet, TX_NONE);
    check("out_accept_drop", rx_accept, 0);
    tick();
    check("out_pkt", tx_packet, acc ? TX_ACK : TX_NAK);
    xmit(len);
    check("out_rx_done", rx_done, acc && fresh);
    check("out_txn_error", txn_error, 0);
    if (acc && fresh) m_rx_tgl = !m_rx_tgl;
    tick();
    buffer_occupancy = 7'd0;
  endtask

  task automatic in_txn(input bit host_ack, input int len);
    tx_pid_t exp;
    exp = m_armed ? (m_tx_tgl ? TX_DATA1 : TX_DATA0) : TX_NAK;
    token(RX_IN);
    check("in_pkt_early", tx_packet, TX_NONE);
    tick();
    check("in_pkt", tx_packet, exp);
    check("in_d_mode", d_mode, 1);
    tick();
    check("in_pkt_width", tx_packet, TX_NONE);
    xmit(len);
    if (m_armed) begin
      token(host_ack ? RX_ACK : RX_NAK);
      check("in_tx_done", tx_done, host_ack);
      check("in_txn_error", txn_error, !host_ack);
      check("in_flush", flush, !host_ack);
      m_armed = 1'b0;
      if (host_ack) m_tx_tgl = !m_tx_tgl;
    end
    check("in_tx_armed", tx_armed, m_armed);
    tick();
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state.
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    check_quiet("post_reset");

    // Fresh OUT DATA0, then the same DATA0 again as a duplicate.
    out_txn(RX_DATA0, 7'd0, 2);
    out_txn(RX_DATA0, 7'd0, 1);

    // IN unarmed -> NAK, then armed -> DATA0 and host ACK.
    in_txn(1'b1, 1);
    arm();
    in_txn(1'b1, 3);

    // Armed IN, host never answers.
    arm();
    token(RX_IN);
    tick();
    check("to_pkt", tx_packet, m_tx_tgl ? TX_DATA1 : TX_DATA0);
    tick();
    xmit(1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * TO) begin
      tick();
      n++;
      seen = txn_error;
    end
    check("to_cycles", n, TO + 1);
    check("to_flush", flush, 1);
    check("to_tx_armed", tx_armed, 0);
    m_armed = 1'b0;
    tick();
    // Same toggle is reused because the timed-out packet was never acknowledged.
    arm();
    in_txn(1'b1, 1);

    // OUT into a non-empty buffer.
    out_txn(RX_DATA1, 7'd5, 2);

    // Non-DATA packet while waiting for OUT data.
    token(RX_OUT);
    check("nd_accept", rx_accept, 1);
    token(RX_IN);
    check("nd_txn_error", txn_error, 1);
    check("nd_flush", flush, 1);
    check("nd_accept_drop", rx_accept, 0);
    tick();

    // Transmit error while sending a fresh ACK: no rx_done, toggle kept.
    token(RX_OUT);
    token(m_rx_tgl ? RX_DATA1 : RX_DATA0);
    tick();
    tx_transfer_active = 1'b1;
    tick();
    tx_error = 1'b1;
    tick();
    tx_error = 1'b0;
    tx_transfer_active = 1'b0;
    check("txe_txn_error", txn_error, 1);
    check("txe_flush", flush, 1);
    check("txe_d_mode", d_mode, 0);
    check("txe_rx_done", rx_done, 0);
    tick();
    out_txn(m_rx_tgl ? RX_DATA1 : RX_DATA0, 7'd0, 1);

    // Arm collides with the ACK that would clear it.
    arm();
    token(RX_IN);
    tick();
    tick();
    xmit(2);
    tx_arm = 1'b1;
    token(RX_ACK);
    tx_arm = 1'b0;
    check("col_tx_done", tx_done, 1);
    check("col_tx_armed", tx_armed, 1);
    m_tx_tgl = !m_tx_tgl;
    tick();

    // Arm landing in the IN_DECIDE cycle belongs to the next IN.
    in_txn(1'b1, 1);
    token(RX_IN);
    tx_arm = 1'b1;
    tick();
    tx_arm = 1'b0;
    check("late_arm_pkt", tx_packet, TX_NAK);
    check("late_arm_flag", tx_armed, 1);
    tick();
    xmit(1);
    m_armed = 1'b1;
    in_txn(1'b1, 1);

`ifdef USB_TXN_STALL_EN
    arm();
    stall = 1'b1;
    token(RX_IN);
    check("stall_early", tx_packet, TX_NONE);
    tick();
    check("stall_pkt", tx_packet, TX_STALL);
    xmit(1);
    check("stall_tx_armed", tx_armed, 1);
    check("stall_tx_done", tx_done, 0);
    stall = 1'b0;
    tick();
    in_txn(1'b1, 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        arm();
      end else if (r == 2) begin
        toggle_clr = 1'b1;
        tick();
        toggle_clr = 1'b0;
        m_rx_tgl = 1'b0;
        m_tx_tgl = 1'b0;
      end else if (r < 6) begin
        out_txn(($urandom_range(0, 1) == 1) ? RX_DATA1 : RX_DATA0,
                ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 64)) : 7'd0,
                int'($urandom_range(1, 4)));
      end else begin
        in_txn($urandom_range(0, 3) != 0, int'($urandom_range(1, 4)));
      end
    end

    // Reset in the middle of a transmit.
    token(RX_OUT);
    token(RX_DATA0);
    tick();
    tx_transfer_active = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_quiet("mid_reset");
    rst = 1'b0;
    tx_transfer_active = 1'b0;
    m_rx_tgl = 1'b0;
    m_tx_tgl = 1'b0;
    m_armed  = 1'b0;
    tick();
    out_txn(RX_DATA0, 7'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_txn_ctrl.md
# usb_txn_ctrl

Transaction sequencer for the USB device datapath. It watches decoded packets from the receiver, decides each transaction's handshake, and drives the transmitter's packet request. It also gates and flushes the shared data buffer and tracks DATA0/DATA1 toggles per direction. It sits beside the AHB subordinate and owns the `tx_packet`, `flush` and `d_mode` signals that software would otherwise drive directly.

## Interface
- `TIMEOUT_CYCLES`, 1024: host-response / bus-idle timeout, in clk cycles.
- `BUF_DEPTH`, 64: data buffer capacity in bytes.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_packet`  in  3  decoded rx PID (`usb_txn_pkg::rx_pid_t`); valid when `rx_data_ready`.
- `rx_data_ready`  in  1  one-cycle pulse: packet complete.
- `rx_error`  in  1  receiver error pulse.
- `tx_transfer_active`  in  1  transmitter busy.
- `tx_error`  in  1  transmitter error pulse.
- `buffer_occupancy`  in  7  bytes in buffer.
- `tx_arm`  in  1  pulse: software has staged an IN payload.
- `toggle_clr`  in  1  pulse: reset both toggles to DATA0.
- `tx_packet`  out  3  transmit request (`usb_txn_pkg::tx_pid_t`), one-cycle pulse.
- `d_mode`  out  1  high while the device owns the bus.
- `flush`  out  1  one-cycle buffer flush.
- `rx_accept`  out  1  enables receiver stores into the buffer.
- `rx_done`, `tx_done`, `txn_error`  out  1 each  one-cycle status pulses.
- `tx_armed`  out  1  IN payload pending.

## Operation
- **rx PIDs:** NONE=0, OUT=1, IN=2, DATA0=3, DATA1=4, ACK=5, NAK=6, OTHER=7.
- **tx PIDs:** NONE=0, DATA0=1, DATA1=2, ACK=3, NAK=4, STALL=5.
- **States:** IDLE, OUT_WAIT, IN_DECIDE, TX_REQ, TX_START, TX_BUSY, ACK_WAIT.
- **IDLE:**
  - `rx_data_ready` with OUT: go to OUT_WAIT. `rx_accept` is set only if `tx_armed`=0 and `buffer_occupancy`=0. Otherwise the transaction is marked busy.
  - `rx_data_ready` with IN: go to IN_DECIDE.
  - Other PIDs and `rx_error`: ignored.
- **OUT_WAIT:**
  - DATA received, busy: send NAK, no flush.
  - DATA received, toggle matches `rx_tgl`: send ACK, flip `rx_tgl`, pulse `rx_done` after TX_BUSY ends.
  - DATA received, toggle mismatch (duplicate): send ACK, pulse `flush`, no toggle change.
  - `rx_error`, or any non-DATA PID: pulse `flush` (if accepting) and `txn_error`, go to IDLE.
  - Timeout: same as `rx_error`.
  - `rx_accept` drops on leaving OUT_WAIT.
- **IN_DECIDE** (one cycle):
  - `tx_armed`=1: send DATA0/DATA1 per `tx_tgl`, then go to ACK_WAIT.
  - Otherwise: send NAK, then go to IDLE.
  - Zero-length payload (armed, occupancy 0) is legal.
- **TX_REQ:** drive `tx_packet` for one cycle, go to TX_START.
- **TX_START:** wait for `tx_transfer_active`=1, then go to TX_BUSY.
- **TX_BUSY:** wait for `tx_transfer_active`=0.
- **Transmit errors:** `tx_error` in TX_START/TX_BUSY, or a TX_START timeout, does the following:
  - pulse `txn_error` and `flush`;
  - clear `tx_armed`;
  - leave toggles unchanged;
  - go to IDLE.
- **ACK_WAIT:**
  - ACK received: flip `tx_tgl`, clear `tx_armed`, pulse `tx_done`.
  - Anything else, `rx_error`, or timeout: pulse `txn_error` and `flush`, clear `tx_armed`.
  - Both paths go to IDLE.
- **`d_mode`:** 1 from TX_REQ through the cycle TX_BUSY exits. Otherwise 0.
- **Arm/clear collisions:** `tx_arm` in the same cycle as an ACK-clear leaves `tx_armed`=1 (arm wins).
- **`toggle_clr`:** applies in any state. It has priority over a same-cycle flip.
- **Timeout counter:**
  - width `$clog2(TIMEOUT_CYCLES+1)`;
  - zeroed on entry to OUT_WAIT, TX_START and ACK_WAIT;
  - saturating;
  - fires when it equals `TIMEOUT_CYCLES`.

## Timing
- **Reset values:** all outputs 0; state IDLE; toggles DATA0; counter 0.
- **Mid-transaction reset:** returns to IDLE next edge without asserting `flush`.
- **Registered outputs:** all outputs are registered.
- **Response latency:** `tx_packet` asserts 2 cycles after the triggering `rx_data_ready` (OUT_WAIT→TX_REQ or IN_DECIDE→TX_REQ).
- **Status pulse timing:**
  - `rx_done`/`tx_done`/`flush` are 1 cycle wide, asserted the cycle after the deciding event.
  - `tx_done` asserts the cycle after ACK.
- **`tx_arm` sampling:** sampled on the clock edge. An arm in the IN_DECIDE cycle is not seen by that transaction.

## Configuration
- **`USB_TXN_STALL_EN` defined:**
  - adds input `stall` (1 bit);
  - while `stall`=1, any OUT or IN token answers STALL after the same 2-cycle latency;
  - the buffer is untouched (`rx_accept`=0), toggles are unchanged, and no status pulse fires.
- **Undefined:** no `stall` port; STALL is never sent.

## Structure
- **Package `usb_txn_pkg`:** `rx_pid_t`, `tx_pid_t`, `state_t` enums and the PID constants. The AHB subordinate and transmitter also import it.
- **Sub-module `usb_txn_timer`:** the timeout counter, with inputs `clear`/`en` and output `expired`.

## Test plan
- OUT, DATA0 (occupancy 0, toggle DATA0) → `tx_packet`=ACK 2 cycles later, `rx_done` pulse, `rx_tgl`=1.
- Repeat OUT with DATA0 while `rx_tgl`=1 → ACK, `flush` pulse, no `rx_done`, `rx_tgl` stays 1.
- IN with `tx_armed`=0 → NAK; then `tx_arm`, IN → DATA0; ACK → `tx_done`, `tx_armed`=0, `tx_tgl`=1.
- IN armed, DATA sent, no response for 1024 cycles → `txn_error` and `flush`, `tx_armed`=0, `tx_tgl` unchanged.
- OUT while `buffer_occupancy`=5 → NAK, `rx_accept` never asserts, no `flush`.
- `tx_error` mid-transmit, plus `rst` during TX_BUSY → IDLE, all outputs 0.
- With `USB_TXN_STALL_EN` and `stall`=1: IN → STALL, `tx_armed` unchanged.
